hilo_muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource in the EXE stage.
- Accepts MULT/DIV commands from the EXE stage and runs an iterative 32-step shift-add multiplier or restoring divider.
- Owns the HI/LO registers and serves MFHI/MFLO reads.
- Asserts a stall to the hazard logic while the resource is busy and a dependent command is present.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 51 +++++
 rtl/hilo_muldiv_ctrl_if.sv | 34 +++
 rtl/hilo_muldiv_ctrl_iter.sv | 67 ++++++
 rtl/hilo_muldiv_ctrl.sv | 138 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl_pkg
// Shared command codes, widths and FSM state encoding for the HI/LO
// multiply/divide resource. The EXE command defines are provided here with
// guards so an existing defines set takes precedence. Hazard and forwarding
// logic can import this package to decode the sequencer state.
// Optional feature macro used by the design: HILO_FAST_MUL_EN.
// ---------------------------------------------------------------------------
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 8
`endif
`ifndef EXE_MULT
`define EXE_MULT 8'h18
`endif
`ifndef EXE_DIV
`define EXE_DIV 8'h1A
`endif
`ifndef EXE_MFHI
`define EXE_MFHI 8'h10
`endif
`ifndef EXE_MFLO
`define EXE_MFLO 8'h12
`endif

package hilo_muldiv_ctrl_pkg;

  localparam int HILO_CMD_W = `EXE_CMD_LEN;

  localparam logic [HILO_CMD_W-1:0] CMD_MULT = `EXE_MULT;
  localparam logic [HILO_CMD_W-1:0] CMD_DIV  = `EXE_DIV;
  localparam logic [HILO_CMD_W-1:0] CMD_MFHI = `EXE_MFHI;
  localparam logic [HILO_CMD_W-1:0] CMD_MFLO = `EXE_MFLO;

  // Sequencer states; encoding is fixed so other pipeline logic may decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } hilo_state_t;

  function automatic logic is_muldiv(input logic [HILO_CMD_W-1:0] cmd);
    return (cmd == CMD_MULT) || (cmd == CMD_DIV);
  endfunction

  function automatic logic uses_hilo(input logic [HILO_CMD_W-1:0] cmd);
    return (cmd == CMD_MULT) || (cmd == CMD_DIV) ||
           (cmd == CMD_MFHI) || (cmd == CMD_MFLO);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl_if
// EXE-stage <-> HI/LO resource bundle.
//   master : EXE stage (drives cmd_valid, exe_cmd, op_a, op_b)
//   slave  : hilo_muldiv_ctrl (drives busy, hilo_stall, hilo_rdata, done,
//            div_by_zero)
// Handshake: cmd_valid is the valid; ~hilo_stall is the ready. A command is
// consumed at a rising edge where cmd_valid=1 and hilo_stall=0; while stalled
// the EXE stage must hold exe_cmd/op_a/op_b stable.
// ---------------------------------------------------------------------------
interface hilo_muldiv_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = hilo_muldiv_ctrl_pkg::HILO_CMD_W
);
  logic              cmd_valid;
  logic [CMD_W-1:0]  exe_cmd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              busy;
  logic              hilo_stall;
  logic [DATA_W-1:0] hilo_rdata;
  logic              done;
  logic              div_by_zero;

  modport master (
    output cmd_valid, exe_cmd, op_a, op_b,
    input  busy, hilo_stall, hilo_rdata, done, div_by_zero
  );

  modport slave (
    input  cmd_valid, exe_cmd, op_a, op_b,
    output busy, hilo_stall, hilo_rdata, done, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv_ctrl_iter.sv
// ---------------------------------------------------------------------------
// hilo_iter_core
// Unsigned magnitude datapath: 32-step shift-add multiplier and restoring
// divider with its iteration counter.
//   start  : load magnitudes, clear counter (one cycle, from FSM)
//   run    : perform one iteration this edge
//   is_div : divide when 1, multiply when 0 (valid on start and run)
//   a_mag/b_mag : |op_a| / |op_b|
//   last   : this run edge is the final iteration
//   hi_mag/lo_mag : MUL -> {hi,lo}=product, DIV -> hi=remainder, lo=quotient
// ---------------------------------------------------------------------------
module hilo_iter_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic              last,
  output logic [DATA_W-1:0] hi_mag,
  output logic [DATA_W-1:0] lo_mag
);
  logic [DATA_W-1:0] opnd;   // multiplicand or divisor
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_trial;
  logic [DATA_W-1:0] div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi_mag} + (lo_mag[0] ? {1'b0, opnd} : '0);
    // Shift the next dividend bit into the partial remainder.
    div_trial = {hi_mag, lo_mag[DATA_W-1]};
    div_ge    = div_trial >= {1'b0, opnd};
    // When div_ge the true difference is below the divisor, so it fits.
    div_diff  = div_trial[DATA_W-1:0] - opnd;
  end

  assign last = run && (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hi_mag <= '0;
      lo_mag <= '0;
      opnd   <= '0;
    end else if (start) begin
      cnt    <= '0;
      hi_mag <= '0;
      lo_mag <= is_div ? a_mag : b_mag;
      opnd   <= is_div ? b_mag : a_mag;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        hi_mag <= div_ge ? div_diff : div_trial[DATA_W-1:0];
        lo_mag <= {lo_mag[DATA_W-2:0], div_ge};
      end else begin
        hi_mag <= mul_sum[DATA_W:1];
        lo_mag <= {mul_sum[0], lo_mag[DATA_W-1:1]};
      end
    end
  end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
// EXE-stage sequencer for the HI/LO multiply/divide resource. Owns HI/LO,
// runs iterative signed MULT/DIV via hilo_iter_core, serves MFHI/MFLO and
// stalls HI/LO-dependent commands while busy.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : hilo_muldiv_ctrl_if.slave (command in, status/read data out)
//   dbg_state : current sequencer state
// Optional macro HILO_FAST_MUL_EN: single-cycle MULT writing HI/LO at the
// accepting edge; DIV stays iterative.
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CMD_W  = HILO_CMD_W,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  hilo_muldiv_ctrl_if.slave   bus,
  output hilo_state_t         dbg_state
);
  hilo_state_t       state, state_nxt;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] hi, lo;
  logic              sign_q, sign_r, dz, op_div;
  logic              start_ok, iter_start, run, fix, core_last, core_is_div;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [2*DATA_W-1:0] mul_res;
  logic              done_q, dbz_q;

  assign cmd      = bus.exe_cmd;
  assign a_neg    = bus.op_a[DATA_W-1];
  assign b_neg    = bus.op_b[DATA_W-1];
  assign a_mag    = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag    = b_neg ? -bus.op_b : bus.op_b;
  assign start_ok = (state == ST_IDLE) && bus.cmd_valid && is_muldiv(cmd);

`ifdef HILO_FAST_MUL_EN
  logic                fast_mul;
  logic [2*DATA_W-1:0] fast_prod;
  assign fast_mul   = start_ok && (cmd == CMD_MULT);
  assign fast_prod  = $signed(bus.op_a) * $signed(bus.op_b);
  assign iter_start = start_ok && !fast_mul;
`else
  assign iter_start = start_ok;
`endif

  // The core takes the mode from the command at start, then from the state.
  assign core_is_div = (state == ST_IDLE) ? (cmd == CMD_DIV) : (state == ST_DIV);

  hilo_iter_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .run    (run),
    .is_div (core_is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .last   (core_last),
    .hi_mag (core_hi),
    .lo_mag (core_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    fix       = 1'b0;
    case (state)
      ST_IDLE: if (iter_start) state_nxt = (cmd == CMD_DIV) ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: begin
        run = 1'b1;
        if (core_last) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        fix       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mul_res = sign_q ? -{core_hi, core_lo} : {core_hi, core_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
      op_div <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (iter_start) begin
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
        op_div <= (cmd == CMD_DIV);
        dz     <= (cmd == CMD_DIV) && (bus.op_b == '0);
      end
      if (fix) begin
        done_q <= 1'b1;
        if (op_div) begin
          // Remainder follows the dividend; for /0 this reproduces op_a.
          hi    <= sign_r ? -core_hi : core_hi;
          lo    <= dz ? '1 : (sign_q ? -core_lo : core_lo);
          dbz_q <= dz;
        end else begin
          {hi, lo} <= mul_res;
        end
      end
`ifdef HILO_FAST_MUL_EN
      if (fast_mul) begin
        {hi, lo} <= fast_prod;
        done_q   <= 1'b1;
      end
`endif
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.hilo_stall  = bus.busy && bus.cmd_valid && uses_hilo(cmd);
  assign bus.hilo_rdata  = (cmd == CMD_MFHI) ? hi : lo;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
// Directed and random MULT/DIV sequences against hilo_muldiv_ctrl. Expected
// HI/LO/div_by_zero come from a behavioural signed model and are queued at
// issue, then popped when done pulses. Honours HILO_FAST_MUL_EN.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int W      = 2*DATA_W + 1;  // {div_by_zero, HI, LO}
  localparam logic [HILO_CMD_W-1:0] CMD_ADD = 8'h20;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
  localparam logic [HILO_CMD_W-1:0] STALL_CMD = CMD_DIV;
`else
  localparam int MUL_BUSY = 33;
  localparam logic [HILO_CMD_W-1:0] STALL_CMD = CMD_MULT;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if #(.DATA_W(DATA_W)) bus ();
  hilo_state_t dbg_state;

  hilo_muldiv_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [HILO_CMD_W-1:0] cmd,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q, r;
    if (cmd == CMD_MULT) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {1'b0, p};
    end
    if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {1'b0, r, q};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.cmd_valid = 1'b0;
    bus.exe_cmd   = CMD_ADD;
    bus.op_a      = '0;
    bus.op_b      = '0;
  endtask

  task automatic drive_cmd(input logic [HILO_CMD_W-1:0] cmd, input logic [31:0] a,
                           input logic [31:0] b);
    bus.cmd_valid = 1'b1;
    bus.exe_cmd   = cmd;
    bus.op_a      = a;
    bus.op_b      = b;
  endtask

  // Called in the low phase; reads HI then LO through the combinational port.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.cmd_valid = 1'b1;
    bus.exe_cmd   = CMD_MFHI;
    #1 hi = bus.hilo_rdata;
    bus.exe_cmd   = CMD_MFLO;
    #1 lo = bus.hilo_rdata;
    idle_bus();
  endtask

  task automatic run_op(input string tag, input logic [HILO_CMD_W-1:0] cmd,
                        input logic [31:0] a, input logic [31:0] b, input int exp_busy);
    logic [W-1:0] e;
    logic [31:0]  hi, lo;
    int           busy_cnt;
    bit           got;
    @(negedge clk);
    drive_cmd(cmd, a, b);
    exp_q.push_back(model(cmd, a, b));
    @(negedge clk);
    idle_bus();
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    e = exp_q.pop_front();
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(e[W-1]));
    read_hilo(hi, lo);
    check({tag, " HI"}, 64'(hi), 64'(e[63:32]));
    check({tag, " LO"}, 64'(lo), 64'(e[31:0]));
    @(negedge clk);
    check({tag, " done_single"}, 64'(bus.done), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] e;
    logic [31:0]  hi, lo;
    int           stall_cnt;
    bit           stalled;
    idle_bus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst dbz", 64'(bus.div_by_zero), 64'd0);
    check("rst state", 64'(dbg_state), 64'(ST_IDLE));
    read_hilo(hi, lo);
    check("rst HI", 64'(hi), 64'd0);
    check("rst LO", 64'(lo), 64'd0);

    // Main function
    run_op("mult_7x-3", CMD_MULT, 32'd7, 32'hFFFF_FFFD, MUL_BUSY);
    run_op("div_-7/2", CMD_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    run_op("div_ovf", CMD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    run_op("div_5/0", CMD_DIV, 32'd5, 32'd0, 33);
    run_op("div_-9/0", CMD_DIV, 32'hFFFF_FFF7, 32'd0, 33);
    run_op("div_-100/-7", CMD_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33);
    run_op("mult_minmin", CMD_MULT, 32'h8000_0000, 32'h8000_0000, MUL_BUSY);
    run_op("mult_2^16sq", CMD_MULT, 32'h0001_0000, 32'h0001_0000, MUL_BUSY);

    // Ignored command when cmd_valid=0
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.exe_cmd   = CMD_DIV;
    bus.op_a      = 32'd1;
    @(negedge clk);
    check("invalid ignored", 64'(bus.busy), 64'd0);
    idle_bus();

    // Stall: ADD during busy proceeds, MFLO held until result lands
    @(negedge clk);
    drive_cmd(STALL_CMD, 32'h1234_5678, 32'd9);
    exp_q.push_back(model(STALL_CMD, 32'h1234_5678, 32'd9));
    @(negedge clk);
    drive_cmd(CMD_ADD, 32'd1, 32'd2);
    #1;
    check("add busy", 64'(bus.busy), 64'd1);
    check("add no stall", 64'(bus.hilo_stall), 64'd0);
    @(negedge clk);
    drive_cmd(CMD_MFLO, 32'd0, 32'd0);
    stall_cnt = 0;
    stalled   = 1'b1;
    for (int i = 0; i < 100 && stalled; i++) begin
      #1;
      if (!bus.hilo_stall) stalled = 1'b0;
      else begin
        stall_cnt++;
        @(negedge clk);
      end
    end
    e = exp_q.pop_front();
    check("mflo stall cycles", 64'(stall_cnt), 64'd32);
    check("mflo rdata", 64'(bus.hilo_rdata), 64'(e[31:0]));
    check("mflo done", 64'(bus.done), 64'd1);
    idle_bus();
    read_hilo(hi, lo);
    check("stall op HI", 64'(hi), 64'(e[63:32]));

    // Reset during a DIV discards the partial result
    @(negedge clk);
    drive_cmd(CMD_DIV, 32'd1000, 32'd7);
    @(negedge clk);
    idle_bus();
    repeat (9) @(negedge clk);
    check("mid-div busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort state", 64'(dbg_state), 64'(ST_IDLE));
    read_hilo(hi, lo);
    check("abort HI", 64'(hi), 64'd0);
    check("abort LO", 64'(lo), 64'd0);
    @(negedge clk);
    check("abort no done", 64'(bus.done), 64'd0);
    run_op("mult_3x4", CMD_MULT, 32'd3, 32'd4, MUL_BUSY);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      logic [HILO_CMD_W-1:0] c;
      logic [31:0] ra, rb;
      c  = ($urandom_range(0, 1) == 1) ? CMD_DIV : CMD_MULT;
      ra = $urandom;
      rb = (i == 2) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op($sformatf("rand%0d", i), c, ra, rb, (c == CMD_DIV) ? 33 : MUL_BUSY);
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
